// File: rtl/result_drain_pkg.sv
// Shared types and helpers for the result drain stage behind the systolic array.
// sat_shift is the plain-arithmetic reference of the ReLU/shift/saturate step.
package result_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int ARRAY_WIDTH  = 4;
  localparam int ARRAY_HEIGHT = 4;
  localparam int NUM_ELEM     = ARRAY_HEIGHT * ARRAY_WIDTH;

  function automatic longint sat_shift(input longint a, input int shift, input bit relu,
                                       input int out_width);
    longint s;
    longint hi;
    longint lo;
    s  = (relu && a < 0) ? 64'sd0 : a;
    s  = s >>> shift;
    hi = (longint'(1) <<< (out_width - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/result_postproc.sv
// Combinational ReLU, arithmetic right shift and signed saturation of one
// accumulator word down to the output element width.
module result_postproc #(
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0,
  parameter int RELU_EN   = 1
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] data
);

  logic signed [ACC_WIDTH-1:0]   relu_val;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [ACC_WIDTH-OUT_WIDTH:0]  top_bits;

  always_comb begin
    relu_val = acc;
    if ((RELU_EN != 0) && acc[ACC_WIDTH-1]) begin
      relu_val = '0;
    end
    shifted  = relu_val >>> SHIFT;
    // The value fits when every bit above the output sign bit copies it.
    top_bits = shifted[ACC_WIDTH-1:OUT_WIDTH-1];
    if ((&top_bits) || (~|top_bits)) begin
      data = shifted[OUT_WIDTH-1:0];
    end else if (shifted[ACC_WIDTH-1]) begin
      data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/result_drain.sv
// Snapshots all PE accumulators on done and streams them out row-major over
// valid/ready, post-processed to OUT_WIDTH signed activations.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int WIDTH     = ARRAY_WIDTH,
  parameter int HEIGHT    = ARRAY_HEIGHT,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0,
  parameter int RELU_EN   = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                done,
  input  logic [HEIGHT*WIDTH*ACC_WIDTH-1:0]   acc_in,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(HEIGHT)-1:0]           out_row,
  output logic [$clog2(WIDTH)-1:0]            out_col,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overrun
);

  localparam int ELEMS = HEIGHT * WIDTH;
  localparam int IDX_W = $clog2(ELEMS);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);

  state_t               state_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [COL_W-1:0]     col_reg;
  logic                 out_valid_reg;
  logic                 out_last_reg;
  logic                 busy_reg;
  logic                 overrun_reg;
  logic [ACC_WIDTH-1:0] snapshot_reg [ELEMS];
  logic [ACC_WIDTH-1:0] sel_acc;
  logic [OUT_WIDTH-1:0] post_data;
  logic                 xfer;
  logic                 capture;

  assign xfer    = out_valid_reg && out_ready;
  // A new frame is accepted when idle or exactly as the final element leaves.
  assign capture = done && ((state_reg == IDLE) || (xfer && out_last_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ELEMS; i++) begin
        snapshot_reg[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < ELEMS; i++) begin
        snapshot_reg[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (done) begin
            state_reg     <= DRAIN;
            idx_reg       <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b1;
            out_last_reg  <= (ELEMS == 1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (out_last_reg) begin
              idx_reg      <= '0;
              row_reg      <= '0;
              col_reg      <= '0;
              out_last_reg <= (ELEMS == 1);
              if (!done) begin
                state_reg     <= IDLE;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
                out_last_reg  <= 1'b0;
              end
            end else begin
              idx_reg      <= idx_reg + 1'b1;
              out_last_reg <= (idx_reg == IDX_W'(ELEMS - 2));
              if (col_reg == COL_W'(WIDTH - 1)) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
              end else begin
                col_reg <= col_reg + 1'b1;
              end
            end
          end
          if (done && !capture) begin
            overrun_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sel_acc = snapshot_reg[idx_reg];

  result_postproc #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .RELU_EN   (RELU_EN)
  ) u_postproc (
    .acc  (sel_acc),
    .data (post_data)
  );

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;
  assign out_data  = out_valid_reg ? post_data : '0;
  assign out_row   = out_valid_reg ? row_reg : '0;
  assign out_col   = out_valid_reg ? col_reg : '0;

endmodule

// File: tb/tb_result_drain.sv
// Randomised and directed bench for result_drain: a queue model of the frame
// stream is compared against three parameter variants every cycle.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 20;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic done;
  logic out_ready;
  logic [H*W*AW-1:0] acc_in;

  logic [OW-1:0] d_a, d_n, d_s;
  logic v_a, v_n, v_s;
  logic [1:0] r_a, r_n, r_s;
  logic [1:0] c_a, c_n, c_s;
  logic l_a, l_n, l_s;
  logic b_a, b_n, b_s;
  logic o_a, o_n, o_s;

  always #5 clk = ~clk;

  result_drain #(.WIDTH(W), .HEIGHT(H), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0), .RELU_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .done(done), .acc_in(acc_in), .out_data(d_a), .out_valid(v_a),
    .out_ready(out_ready), .out_row(r_a), .out_col(c_a), .out_last(l_a), .busy(b_a), .overrun(o_a));

  result_drain #(.WIDTH(W), .HEIGHT(H), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0), .RELU_EN(0)) u_norelu (
    .clk(clk), .rst_n(rst_n), .done(done), .acc_in(acc_in), .out_data(d_n), .out_valid(v_n),
    .out_ready(out_ready), .out_row(r_n), .out_col(c_n), .out_last(l_n), .busy(b_n), .overrun(o_n));

  result_drain #(.WIDTH(W), .HEIGHT(H), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(2), .RELU_EN(1)) u_shift2 (
    .clk(clk), .rst_n(rst_n), .done(done), .acc_in(acc_in), .out_data(d_s), .out_valid(v_s),
    .out_ready(out_ready), .out_row(r_s), .out_col(c_s), .out_last(l_s), .busy(b_s), .overrun(o_s));

  typedef struct {
    int row;
    int col;
    bit last;
    int d0;
    int dn;
    int ds;
  } elem_t;

  elem_t exp_q[$];
  elem_t xlog[$];
  bit    exp_ovr;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_at(input logic [H*W*AW-1:0] v, input int i);
    logic signed [AW-1:0] a;
    a = v[i*AW +: AW];
    return int'(a);
  endfunction

  // Frame-level model: a capture enqueues a whole frame, each handshake pops one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      bit was_empty;
      bit last_x;
      elem_t e;
      int a;
      was_empty = (exp_q.size() == 0);
      last_x    = 1'b0;
      exp_ovr   = 1'b0;
      if (!was_empty && out_ready) begin
        last_x = (exp_q.size() == 1);
        void'(exp_q.pop_front());
      end
      if (done) begin
        if (was_empty || last_x) begin
          for (int i = 0; i < NUM_ELEM; i++) begin
            a      = acc_at(acc_in, i);
            e.row  = i / W;
            e.col  = i % W;
            e.last = (i == NUM_ELEM - 1);
            e.d0   = int'(sat_shift(longint'(a), 0, 1'b1, OW));
            e.dn   = int'(sat_shift(longint'(a), 0, 1'b0, OW));
            e.ds   = int'(sat_shift(longint'(a), 2, 1'b1, OW));
            exp_q.push_back(e);
          end
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit ev;
      elem_t e;
      ev = (exp_q.size() > 0);
      chk("valid", longint'(v_a), longint'(ev));
      chk("valid_norelu", longint'(v_n), longint'(ev));
      chk("valid_shift2", longint'(v_s), longint'(ev));
      chk("busy", longint'(b_a), longint'(ev));
      chk("overrun", longint'(o_a), longint'(exp_ovr));
      if (ev) begin
        e = exp_q[0];
        chk("row", longint'(r_a), e.row);
        chk("col", longint'(c_a), e.col);
        chk("last", longint'(l_a), longint'(e.last));
        chk("data", longint'($signed(d_a)), e.d0);
        chk("data_norelu", longint'($signed(d_n)), e.dn);
        chk("data_shift2", longint'($signed(d_s)), e.ds);
      end else begin
        chk("idle_data", longint'(d_a), 0);
        chk("idle_row", longint'(r_a), 0);
        chk("idle_col", longint'(c_a), 0);
        chk("idle_last", longint'(l_a), 0);
      end
      if (v_a && out_ready) begin
        e.row  = int'(r_a);
        e.col  = int'(c_a);
        e.last = l_a;
        e.d0   = int'($signed(d_a));
        e.dn   = int'($signed(d_n));
        e.ds   = int'($signed(d_s));
        xlog.push_back(e);
        $display("xfer row=%0d col=%0d last=%0d data=%0d norelu=%0d shift2=%0d",
                 e.row, e.col, e.last, e.d0, e.dn, e.ds);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_acc(input int i, input int v);
    acc_in[i*AW +: AW] = v[AW-1:0];
  endtask

  task automatic rand_acc();
    for (int i = 0; i < NUM_ELEM; i++) begin
      set_acc(i, int'($urandom_range(0, (1 << AW) - 1)));
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (b_a && n < maxc) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", longint'(b_a), 0);
  endtask

  task automatic wait_pos(input int r, input int c, input int maxc);
    int n;
    n = 0;
    while (!(v_a && int'(r_a) == r && int'(c_a) == c) && n < maxc) begin
      cyc(1);
      n++;
    end
    chk("pos_timeout", longint'(v_a && int'(r_a) == r && int'(c_a) == c), 1);
  endtask

  initial begin
    logic [OW-1:0] held;
    rst_n     = 1'b0;
    done      = 1'b0;
    out_ready = 1'b0;
    acc_in    = '0;
    cyc(3);
    chk("rst_valid", longint'(v_a), 0);
    chk("rst_busy", longint'(b_a), 0);
    chk("rst_overrun", longint'(o_a), 0);
    chk("rst_last", longint'(l_a), 0);
    chk("rst_data", longint'(d_a), 0);
    rst_n = 1'b1;
    cyc(2);

    // Basic drain with identity ramp.
    for (int i = 0; i < NUM_ELEM; i++) set_acc(i, i);
    out_ready = 1'b1;
    xlog.delete();
    pulse_done();
    chk("latency_valid", longint'(v_a), 1);
    wait_idle(100);
    chk("basic_count", xlog.size(), 16);
    for (int i = 0; i < xlog.size() && i < 16; i++) begin
      chk("basic_data", xlog[i].d0, i);
      chk("basic_row", xlog[i].row, i / 4);
      chk("basic_col", xlog[i].col, i % 4);
      chk("basic_last", longint'(xlog[i].last), longint'(i == 15));
    end

    // Saturation and ReLU across the three variants.
    acc_in = '0;
    set_acc(0, 300);
    set_acc(1, -5);
    set_acc(2, -300);
    xlog.delete();
    pulse_done();
    wait_idle(100);
    chk("sat_count", xlog.size(), 16);
    if (xlog.size() >= 3) begin
      chk("sat_pos_relu", xlog[0].d0, 127);
      chk("sat_pos_norelu", xlog[0].dn, 127);
      chk("sat_pos_shift2", xlog[0].ds, 75);
      chk("neg5_relu", xlog[1].d0, 0);
      chk("neg5_norelu", xlog[1].dn, -5);
      chk("neg5_shift2", xlog[1].ds, 0);
      chk("neg300_relu", xlog[2].d0, 0);
      chk("neg300_norelu", xlog[2].dn, -128);
      chk("neg300_shift2", xlog[2].ds, 0);
    end

    // Backpressure: stall on element 3, then toggle ready.
    rand_acc();
    xlog.delete();
    pulse_done();
    wait_pos(0, 3, 50);
    out_ready = 1'b0;
    held = d_a;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("stall_data", longint'(d_a), longint'(held));
      chk("stall_col", longint'(c_a), 3);
    end
    for (int k = 0; k < 100 && b_a; k++) begin
      out_ready = ~out_ready;
      cyc(1);
    end
    out_ready = 1'b1;
    wait_idle(50);
    chk("bp_count", xlog.size(), 16);
    for (int i = 0; i < xlog.size() && i < 16; i++) begin
      chk("bp_order", xlog[i].row * 4 + xlog[i].col, i);
    end

    // Overrun mid-frame, then back-to-back capture on the final transfer.
    rand_acc();
    xlog.delete();
    pulse_done();
    wait_pos(1, 1, 50);
    rand_acc();
    pulse_done();
    chk("overrun_pulse", longint'(o_a), 1);
    cyc(1);
    chk("overrun_clear", longint'(o_a), 0);
    wait_pos(3, 3, 50);
    for (int i = 0; i < NUM_ELEM; i++) set_acc(i, 100 + i);
    pulse_done();
    chk("b2b_valid", longint'(v_a), 1);
    chk("b2b_row", longint'(r_a), 0);
    chk("b2b_col", longint'(c_a), 0);
    chk("b2b_data", longint'($signed(d_a)), 100);
    chk("b2b_overrun", longint'(o_a), 0);
    wait_idle(100);
    chk("b2b_count", xlog.size(), 32);

    // Reset in the middle of a drain.
    rand_acc();
    pulse_done();
    wait_pos(1, 2, 50);
    pulse_done();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(v_a), 0);
    chk("midrst_busy", longint'(b_a), 0);
    chk("midrst_overrun", longint'(o_a), 0);
    cyc(2);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("postrst_idle", longint'(v_a), 0);
    end
    pulse_done();
    chk("restart_valid", longint'(v_a), 1);
    chk("restart_row", longint'(r_a), 0);
    chk("restart_col", longint'(c_a), 0);
    wait_idle(100);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      rand_acc();
      out_ready = ($urandom_range(0, 9) < 7);
      done      = ($urandom_range(0, 19) == 0);
      cyc(1);
    end
    done      = 1'b0;
    out_ready = 1'b1;
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
